// File: rtl/menu_pkg.sv
// Shared types, colour table and sizing for the menu image buffer writer.
package menu_pkg;

  localparam int unsigned CELL_ROWS_MAX = 128;
  localparam int unsigned CELL_COLS_MAX = 128;
  localparam int unsigned CELL_W        = $clog2(CELL_ROWS_MAX);
  localparam int unsigned ADDR_W        = 2 * CELL_W;
  localparam int unsigned RGB_W         = 12;

  typedef enum logic [1:0] {
    SCR_MENU   = 2'd0,
    SCR_DONKEY = 2'd1,
    SCR_KONG   = 2'd2
  } screen_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [RGB_W-1:0] MENU_BG       = 12'h000;
  localparam logic [RGB_W-1:0] MENU_BORDER   = 12'hFFF;
  localparam logic [RGB_W-1:0] MENU_BANNER   = 12'h00F;
  localparam logic [RGB_W-1:0] DONKEY_BG     = 12'hFFF;
  localparam logic [RGB_W-1:0] DONKEY_BORDER = 12'h000;
  localparam logic [RGB_W-1:0] DONKEY_BANNER = 12'h0F0;
  localparam logic [RGB_W-1:0] KONG_BG       = 12'hF0A;
  localparam logic [RGB_W-1:0] KONG_BORDER   = 12'h000;
  localparam logic [RGB_W-1:0] KONG_BANNER   = 12'hF00;

  // Unused select code 3 falls back to the start menu.
  function automatic screen_t sel_to_screen(input logic [1:0] sel);
    case (sel)
      2'd1:    return SCR_DONKEY;
      2'd2:    return SCR_KONG;
      default: return SCR_MENU;
    endcase
  endfunction

endpackage

// File: rtl/menu_buffer_writer_if.sv
// Write-side valid/ready port of the dual-port menu RAM.
interface menu_buffer_writer_if;
  import menu_pkg::*;

  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [RGB_W-1:0]  wr_data;
  logic              wr_ready;

  modport master (output wr_en, output wr_addr, output wr_data, input wr_ready);
  modport slave  (input wr_en, input wr_addr, input wr_data, output wr_ready);
endinterface

// File: rtl/menu_cell_color.sv
// Combinational colour of one cell: border over banner over background.
module menu_cell_color
  import menu_pkg::*;
#(
  parameter int unsigned ROWS        = 96,
  parameter int unsigned COLS        = 128,
  parameter int unsigned BORDER_W    = 2,
  parameter int unsigned BANNER_TOP  = 40,
  parameter int unsigned BANNER_H    = 16,
  parameter int unsigned BANNER_LEFT = 32,
  parameter int unsigned BANNER_W    = 64
) (
  input  screen_t           scr,
  input  logic [CELL_W-1:0] row,
  input  logic [CELL_W-1:0] col,
  output logic [RGB_W-1:0]  rgb_c
);

  localparam logic [CELL_W-1:0] EDGE_W     = CELL_W'(BORDER_W);
  localparam logic [CELL_W-1:0] ROW_BOTTOM = CELL_W'(ROWS - BORDER_W);
  localparam logic [CELL_W-1:0] COL_RIGHT  = CELL_W'(COLS - BORDER_W);
  localparam logic [CELL_W-1:0] BAN_T      = CELL_W'(BANNER_TOP);
  localparam logic [CELL_W-1:0] BAN_B      = CELL_W'(BANNER_TOP + BANNER_H);
  localparam logic [CELL_W-1:0] BAN_L      = CELL_W'(BANNER_LEFT);
  localparam logic [CELL_W-1:0] BAN_R      = CELL_W'(BANNER_LEFT + BANNER_W);

  logic is_border;
  logic is_banner;

  always_comb begin
    is_border = (row < EDGE_W) || (row >= ROW_BOTTOM) ||
                (col < EDGE_W) || (col >= COL_RIGHT);
    is_banner = (row >= BAN_T) && (row < BAN_B) &&
                (col >= BAN_L) && (col < BAN_R);
  end

  always_comb begin
    rgb_c = MENU_BG;
    case (scr)
      SCR_DONKEY: rgb_c = is_border ? DONKEY_BORDER : (is_banner ? DONKEY_BANNER : DONKEY_BG);
      SCR_KONG:   rgb_c = is_border ? KONG_BORDER   : (is_banner ? KONG_BANNER   : KONG_BG);
      default:    rgb_c = is_border ? MENU_BORDER   : (is_banner ? MENU_BANNER   : MENU_BG);
    endcase
  end

endmodule

// File: rtl/menu_buffer_writer.sv
// Writes one full menu/win screen into the menu RAM, one cell per accepted write,
// row-major with address {row, col}.
module menu_buffer_writer
  import menu_pkg::*;
#(
  parameter int unsigned ROWS        = 96,
  parameter int unsigned COLS        = 128,
  parameter int unsigned BORDER_W    = 2,
  parameter int unsigned BANNER_TOP  = 40,
  parameter int unsigned BANNER_H    = 16,
  parameter int unsigned BANNER_LEFT = 32,
  parameter int unsigned BANNER_W    = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  draw_req,
  input  logic [1:0]            screen_sel,
  menu_buffer_writer_if.master  wr,
  output logic                  busy,
  output logic                  done
);

  localparam logic [CELL_W-1:0] LAST_ROW = CELL_W'(ROWS - 1);
  localparam logic [CELL_W-1:0] LAST_COL = CELL_W'(COLS - 1);

  state_t            state;
  screen_t           scr;
  logic [CELL_W-1:0] row;
  logic [CELL_W-1:0] col;
  logic              wr_en_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [RGB_W-1:0]  wr_data_q;

  logic [CELL_W-1:0] next_row_c;
  logic [CELL_W-1:0] next_col_c;
  logic              last_cell_c;
  screen_t           color_scr_c;
  logic [CELL_W-1:0] color_row_c;
  logic [CELL_W-1:0] color_col_c;
  logic [RGB_W-1:0]  cell_rgb_c;

  // Next cell in scan order; in IDLE the colour lookup serves cell (0,0) of the requested screen.
  always_comb begin
    last_cell_c = (row == LAST_ROW) && (col == LAST_COL);
    next_col_c  = (col == LAST_COL) ? '0 : col + CELL_W'(1);
    next_row_c  = (col == LAST_COL) ? row + CELL_W'(1) : row;
    color_scr_c = scr;
    color_row_c = next_row_c;
    color_col_c = next_col_c;
    if (state == ST_IDLE) begin
      color_scr_c = sel_to_screen(screen_sel);
      color_row_c = '0;
      color_col_c = '0;
    end
  end

  menu_cell_color #(
    .ROWS       (ROWS),
    .COLS       (COLS),
    .BORDER_W   (BORDER_W),
    .BANNER_TOP (BANNER_TOP),
    .BANNER_H   (BANNER_H),
    .BANNER_LEFT(BANNER_LEFT),
    .BANNER_W   (BANNER_W)
  ) u_cell_color (
    .scr  (color_scr_c),
    .row  (color_row_c),
    .col  (color_col_c),
    .rgb_c(cell_rgb_c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      scr       <= SCR_MENU;
      row       <= '0;
      col       <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (draw_req) begin
            state     <= ST_FILL;
            scr       <= sel_to_screen(screen_sel);
            row       <= '0;
            col       <= '0;
            wr_en_q   <= 1'b1;
            wr_addr_q <= '0;
            wr_data_q <= cell_rgb_c;
            busy      <= 1'b1;
          end
        end
        ST_FILL: begin
          // Outputs only advance on acceptance, so a stall freezes the presented cell.
          if (wr.wr_ready) begin
            if (last_cell_c) begin
              state   <= ST_DONE;
              wr_en_q <= 1'b0;
              done    <= 1'b1;
            end else begin
              row       <= next_row_c;
              col       <= next_col_c;
              wr_addr_q <= {next_row_c, next_col_c};
              wr_data_q <= cell_rgb_c;
            end
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: begin
          state   <= ST_IDLE;
          wr_en_q <= 1'b0;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

  assign wr.wr_en   = wr_en_q;
  assign wr.wr_addr = wr_addr_q;
  assign wr.wr_data = wr_data_q;

endmodule
